user_panel_ctrl: RTL and testbench
==================================

# user_panel_ctrl

Parametrised front-panel controller between the board pins (KEY, SW, HEX, LEDR) and the user_module conduit of the PCIe/SDRAM system. It debounces the push-buttons and emits one-cycle action strobes with the switch-selected read/write mode latched. It drives an N-digit seven-segment display from one of NUM_CH selectable 32-bit status channels, with a hold mode. It also maintains a sticky debug-flag LED register with explicit clear.

## Interface
Parameters:
- NUM_CH, 4: number of display channels (≥1); CH_W = max(1, clog2(NUM_CH)).
- DATAWIDTH, 32: channel width; multiple of 4; NUM_DIGITS = DATAWIDTH/4.
- DEBOUNCE_CYCLES, 500000: stable-level cycles before a key change is accepted (10 ms at 50 MHz); ≥2.
- NUM_LEDS, 18: sticky LED count; IDX_W = clog2(NUM_LEDS).

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high.
- key_n  in  2  raw active-low buttons; [0] action, [1] channel-next.
- rdwr_cntl_sw  in  1  raw switch, 1 = write.
- add_data_sel_sw  in  1  raw switch, 1 = data, 0 = address.
- display_hold  in  1  1 freezes displayed value.
- ch_data  in  NUM_CH*DATAWIDTH  channel k at [k*DATAWIDTH +: DATAWIDTH].
- debug_valid  in  1  strobe: set LED debug_idx.
- debug_idx  in  IDX_W  LED index.
- led_clear  in  1  clear all sticky LEDs.
- action_pulse  out  1  one-cycle strobe per accepted action press.
- action_rdwr  out  1  rdwr_cntl_sw captured at the strobe.
- action_sel  out  1  add_data_sel_sw captured at the strobe.
- ch_sel  out  CH_W  currently displayed channel.
- hex_n  out  7*NUM_DIGITS  active-low segments; digit d at [7d +: 7], bit order gfedcba.
- ledr  out  NUM_LEDS  sticky debug LEDs.

## Operation
- Reset values: action_pulse 0, action_rdwr 0, action_sel 0, ch_sel 0, ledr 0, hex_n all 1 (blank), debounced key state 1 (released), debounce counters 0.
- Per key: 2-flop synchroniser, then counter. If synced level ≠ stable state, counter increments, else counter clears. When counter reaches DEBOUNCE_CYCLES-1 and level still differs, stable state takes the level and counter clears. Any bounce back before that clears the counter.
- Press = stable state 1→0. Release generates nothing. Holding a key generates one event.
- key 0 press: action_pulse = 1 for exactly one cycle. action_rdwr/action_sel register the synchronised switch values in that same cycle and hold until the next press. Switches pass through a 2-flop synchroniser.
- key 1 press: ch_sel ← ch_sel+1, wrapping NUM_CH-1 → 0. With NUM_CH = 1, ch_sel stays 0.
- Display: shown register ← ch_data[ch_sel] every cycle unless display_hold = 1. Digit d decodes nibble [4d+3:4d]. Codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Sticky LEDs: debug_valid with debug_idx < NUM_LEDS sets ledr[debug_idx]. An index ≥ NUM_LEDS is ignored. led_clear clears all bits. When both occur in the same cycle, led_clear applies first, so only the new bit ends up set.
- reset asserted mid-debounce or mid-strobe: everything returns to reset values on that edge. No pending press survives reset.

## Timing
- Key latency: raw key low, sampled at edge 0 and stable thereafter → action_pulse high in cycle 2+DEBOUNCE_CYCLES+1 exactly, for 1 cycle. Same latency for ch_sel increment.
- Release requires the same stability before another press is recognised. Minimum press-to-press spacing is 2*DEBOUNCE_CYCLES.
- Display latency: ch_data or ch_sel change → hex_n updated 2 cycles later (select register, decode register).
- display_hold takes effect on the next edge. Releasing hold shows current data after 2 cycles.
- ledr updates 1 cycle after debug_valid/led_clear.

## Test plan
- Clean press, DEBOUNCE_CYCLES=4, rdwr_cntl_sw=1, add_data_sel_sw=0: key_n[0] low at edge 0 → action_pulse high only in cycle 7; action_rdwr=1, action_sel=0; no pulse on release.
- Bounce, DEBOUNCE_CYCLES=4: key_n[0] low for 3 cycles, high 1, then low steady → no pulse during bounce; single pulse 7 cycles after the final low edge.
- Channel wrap, NUM_CH=3, ch_data = {0x33333333, 0x22222222, 0x11111111}: four key 1 presses → ch_sel 1,2,0,1. hex_n digit 0 = 0100100 two cycles after ch_sel=1. display_hold=1 then ch_data change → hex_n unchanged.
- Hex decode: ch_data[0]=0x89ABCDEF → digits 0..7 = 0001110, 0000110, 0100001, 1000110, 0000011, 0001000, 0010000, 0000000.
- Sticky LEDs, NUM_LEDS=18: set idx 5, 17, 20 → ledr=0x20020. Simultaneous led_clear and idx 3 → ledr=0x00008.
- Reset mid-debounce: reset at count 2 of 4 with key held low → no pulse. ch_sel=0, hex_n all 1, ledr=0. Key still low after reset → pulse 7 cycles after reset deasserts.

Source files
------------

// File: rtl/user_panel_ctrl.sv
// Front-panel controller: debounced action/channel keys, switch-latched action strobe,
// selectable seven-segment status display with hold, and sticky debug LEDs.
module user_panel_ctrl #(
  parameter int NUM_CH          = 4,
  parameter int DATAWIDTH       = 32,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_LEDS        = 18,
  localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int NUM_DIGITS     = DATAWIDTH / 4,
  localparam int IDX_W          = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  key_n,
  input  logic                        rdwr_cntl_sw,
  input  logic                        add_data_sel_sw,
  input  logic                        display_hold,
  input  logic [NUM_CH*DATAWIDTH-1:0] ch_data,
  input  logic                        debug_valid,
  input  logic [IDX_W-1:0]            debug_idx,
  input  logic                        led_clear,
  output logic                        action_pulse,
  output logic                        action_rdwr,
  output logic                        action_sel,
  output logic [CH_W-1:0]             ch_sel,
  output logic [7*NUM_DIGITS-1:0]     hex_n,
  output logic [NUM_LEDS-1:0]         ledr
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CH_W-1:0]  CH_LAST = CH_W'(NUM_CH - 1);

  logic [1:0]           r_key_s1;
  logic [1:0]           r_key_s2;
  logic [1:0]           r_key_stable;
  logic [1:0]           r_key_prev;
  logic [CNT_W-1:0]     r_cnt [2];
  logic [1:0]           r_sw_s1;
  logic [1:0]           r_sw_s2;
  logic [1:0]           w_press;

  logic                 r_action_pulse;
  logic                 r_action_rdwr;
  logic                 r_action_sel;
  logic [CH_W-1:0]      r_ch_sel;

  logic [DATAWIDTH-1:0]    w_sel_data;
  logic [DATAWIDTH-1:0]    r_shown_p0;
  logic [7*NUM_DIGITS-1:0] w_hex_dec;
  logic [7*NUM_DIGITS-1:0] r_hex_p1;

  logic [NUM_LEDS-1:0]  r_ledr;
  logic [NUM_LEDS-1:0]  w_led_next;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Key synchronisers and debounce: a change is accepted only after a full run of stable samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_s1     <= 2'b11;
      r_key_s2     <= 2'b11;
      r_key_stable <= 2'b11;
      r_key_prev   <= 2'b11;
      r_sw_s1      <= 2'b00;
      r_sw_s2      <= 2'b00;
      for (int k = 0; k < 2; k++) r_cnt[k] <= '0;
    end else begin
      r_key_s1   <= key_n;
      r_key_s2   <= r_key_s1;
      r_key_prev <= r_key_stable;
      r_sw_s1    <= {add_data_sel_sw, rdwr_cntl_sw};
      r_sw_s2    <= r_sw_s1;
      for (int k = 0; k < 2; k++) begin
        if (r_key_s2[k] != r_key_stable[k]) begin
          if (r_cnt[k] == CNT_MAX) begin
            r_key_stable[k] <= r_key_s2[k];
            r_cnt[k]        <= '0;
          end else begin
            r_cnt[k] <= r_cnt[k] + CNT_W'(1);
          end
        end else begin
          r_cnt[k] <= '0;
        end
      end
    end
  end

  // A press is the stable level falling; releases are ignored.
  assign w_press = r_key_prev & ~r_key_stable;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_action_pulse <= 1'b0;
      r_action_rdwr  <= 1'b0;
      r_action_sel   <= 1'b0;
      r_ch_sel       <= '0;
    end else begin
      r_action_pulse <= w_press[0];
      if (w_press[0]) begin
        r_action_rdwr <= r_sw_s2[0];
        r_action_sel  <= r_sw_s2[1];
      end
      if (w_press[1]) r_ch_sel <= (r_ch_sel == CH_LAST) ? '0 : r_ch_sel + CH_W'(1);
    end
  end

  always_comb begin
    w_sel_data = ch_data[0 +: DATAWIDTH];
    for (int k = 1; k < NUM_CH; k++) begin
      if (r_ch_sel == CH_W'(k)) w_sel_data = ch_data[k*DATAWIDTH +: DATAWIDTH];
    end
  end

  // Stage p0: selected channel capture (frozen while held).
  always_ff @(posedge clk) begin
    if (!display_hold) r_shown_p0 <= w_sel_data;
  end

  always_comb begin
    w_hex_dec = '1;
    for (int d = 0; d < NUM_DIGITS; d++) w_hex_dec[7*d +: 7] = seg7(r_shown_p0[4*d +: 4]);
  end

  // Stage p1: registered segment drive, blank out of reset.
  always_ff @(posedge clk) begin
    if (reset) r_hex_p1 <= '1;
    else       r_hex_p1 <= w_hex_dec;
  end

  // Clear takes priority over the old contents but not over a same-cycle set.
  always_comb begin
    w_led_next = led_clear ? '0 : r_ledr;
    if (debug_valid && (32'(debug_idx) < NUM_LEDS)) w_led_next[debug_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) r_ledr <= '0;
    else       r_ledr <= w_led_next;
  end

  assign action_pulse = r_action_pulse;
  assign action_rdwr  = r_action_rdwr;
  assign action_sel   = r_action_sel;
  assign ch_sel       = r_ch_sel;
  assign hex_n        = r_hex_p1;
  assign ledr         = r_ledr;

endmodule

// File: tb/tb_user_panel_ctrl.sv
// Bench for user_panel_ctrl: decode table vectors, scoreboarded action strobes and
// display updates, plus hand sequences for bounce, channel wrap, hold, LEDs and reset.
module tb_user_panel_ctrl;
  localparam int NUM_CH = 3;
  localparam int DW     = 32;
  localparam int DEB    = 4;
  localparam int NL     = 18;
  localparam int CH_W   = 2;
  localparam int ND     = 8;
  localparam int IDX_W  = 5;

  logic                 clk;
  logic                 reset;
  logic [1:0]           key_n;
  logic                 rdwr_cntl_sw;
  logic                 add_data_sel_sw;
  logic                 display_hold;
  logic [NUM_CH*DW-1:0] ch_data;
  logic                 debug_valid;
  logic [IDX_W-1:0]     debug_idx;
  logic                 led_clear;
  logic                 action_pulse;
  logic                 action_rdwr;
  logic                 action_sel;
  logic [CH_W-1:0]      ch_sel;
  logic [7*ND-1:0]      hex_n;
  logic [NL-1:0]        ledr;

  user_panel_ctrl #(.NUM_CH(NUM_CH), .DATAWIDTH(DW), .DEBOUNCE_CYCLES(DEB), .NUM_LEDS(NL)) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .rdwr_cntl_sw(rdwr_cntl_sw),
    .add_data_sel_sw(add_data_sel_sw), .display_hold(display_hold), .ch_data(ch_data),
    .debug_valid(debug_valid), .debug_idx(debug_idx), .led_clear(led_clear),
    .action_pulse(action_pulse), .action_rdwr(action_rdwr), .action_sel(action_sel),
    .ch_sel(ch_sel), .hex_n(hex_n), .ledr(ledr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int cyc; logic rdwr; logic sel; } pulse_t;
  typedef struct { int cyc; logic [7*ND-1:0] hex; string name; } hex_t;
  typedef struct { logic [3:0] nib; logic [6:0] seg; } vec_t;

  pulse_t pq[$];
  hex_t   hq[$];
  vec_t   vec [16];
  logic [6:0] chseg [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_hex(input int c, input logic [7*ND-1:0] h, input string n);
    hex_t e;
    e.cyc = c; e.hex = h; e.name = n;
    hq.push_back(e);
  endtask

  task automatic push_pulse(input int c, input logic rd, input logic sl);
    pulse_t p;
    p.cyc = c; p.rdwr = rd; p.sel = sl;
    pq.push_back(p);
  endtask

  // Scoreboard: strobes must appear exactly in their predicted cycle, nowhere else.
  always @(negedge clk) begin
    if (action_pulse === 1'b1) begin
      if (pq.size() > 0 && pq[0].cyc == cyc) begin
        checks++;
        chk("pulse_rdwr", 64'(action_rdwr), 64'(pq[0].rdwr));
        chk("pulse_sel", 64'(action_sel), 64'(pq[0].sel));
        pq.delete(0);
      end else begin
        checks++; errors++;
        $display("FAIL pulse_unexpected: action_pulse=1 at cycle %0d, required 0", cyc);
      end
    end else if (pq.size() > 0 && pq[0].cyc <= cyc) begin
      checks++; errors++;
      $display("FAIL pulse_missing: action_pulse=0 at cycle %0d, required 1", pq[0].cyc);
      pq.delete(0);
    end
    while (hq.size() > 0 && hq[0].cyc <= cyc) begin
      chk(hq[0].name, 64'(hex_n), 64'(hq[0].hex));
      hq.delete(0);
    end
  end

  task automatic press_key0(input logic rd, input logic sl);
    key_n[0] = 1'b0;
    push_pulse(cyc + 1 + DEB + 2, rd, sl);
    repeat (12) tick();
    key_n[0] = 1'b1;
    repeat (12) tick();
  endtask

  task automatic press_ch(input logic [1:0] old_sel, input logic [1:0] new_sel);
    int e0;
    key_n[1] = 1'b0;
    e0 = cyc + 1;
    push_hex(e0 + DEB + 3, {ND{chseg[old_sel]}}, "ch_hex_old");
    push_hex(e0 + DEB + 4, {ND{chseg[new_sel]}}, "ch_hex_new");
    while (cyc < e0 + DEB + 1) @(negedge clk);
    chk("ch_sel_before", 64'(ch_sel), 64'(old_sel));
    @(negedge clk);
    chk("ch_sel_after", 64'(ch_sel), 64'(new_sel));
    repeat (10) tick();
    key_n[1] = 1'b1;
    repeat (12) tick();
  endtask

  task automatic led_op(input logic v, input logic [IDX_W-1:0] idx, input logic clr,
                        input logic [NL-1:0] exp, input string n);
    debug_valid = v; debug_idx = idx; led_clear = clr;
    tick();
    chk(n, 64'(ledr), 64'(exp));
    debug_valid = 1'b0; led_clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec[0]  = '{4'h0, 7'b1000000}; vec[1]  = '{4'h1, 7'b1111001};
    vec[2]  = '{4'h2, 7'b0100100}; vec[3]  = '{4'h3, 7'b0110000};
    vec[4]  = '{4'h4, 7'b0011001}; vec[5]  = '{4'h5, 7'b0010010};
    vec[6]  = '{4'h6, 7'b0000010}; vec[7]  = '{4'h7, 7'b1111000};
    vec[8]  = '{4'h8, 7'b0000000}; vec[9]  = '{4'h9, 7'b0010000};
    vec[10] = '{4'hA, 7'b0001000}; vec[11] = '{4'hB, 7'b0000011};
    vec[12] = '{4'hC, 7'b1000110}; vec[13] = '{4'hD, 7'b0100001};
    vec[14] = '{4'hE, 7'b0000110}; vec[15] = '{4'hF, 7'b0001110};
    chseg[0] = 7'b1111001; chseg[1] = 7'b0100100; chseg[2] = 7'b0110000;

    reset = 1'b1; key_n = 2'b11; rdwr_cntl_sw = 1'b0; add_data_sel_sw = 1'b0;
    display_hold = 1'b0; ch_data = '0; debug_valid = 1'b0; debug_idx = '0; led_clear = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_pulse", 64'(action_pulse), 64'd0);
    chk("rst_rdwr", 64'(action_rdwr), 64'd0);
    chk("rst_sel", 64'(action_sel), 64'd0);
    chk("rst_ch_sel", 64'(ch_sel), 64'd0);
    chk("rst_ledr", 64'(ledr), 64'd0);
    chk("rst_hex", 64'(hex_n), {8'h00, {56{1'b1}}});
    tick();
    reset = 1'b0;

    // Decode table, one vector per cycle through the two-stage display pipe.
    for (int i = 0; i < 16; i++) begin
      ch_data = {NUM_CH{ {ND{vec[i].nib}} }};
      push_hex(cyc + 2, {ND{vec[i].seg}}, "hex_table");
      tick();
    end
    ch_data = {NUM_CH{32'h89ABCDEF}};
    push_hex(cyc + 2, {7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                       7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110}, "hex_mixed");
    repeat (4) tick();

    // Clean presses with two switch settings.
    rdwr_cntl_sw = 1'b1; add_data_sel_sw = 1'b0;
    repeat (4) tick();
    press_key0(1'b1, 1'b0);
    rdwr_cntl_sw = 1'b0; add_data_sel_sw = 1'b1;
    repeat (4) tick();
    press_key0(1'b0, 1'b1);
    chk("action_hold_rdwr", 64'(action_rdwr), 64'd0);
    chk("action_hold_sel", 64'(action_sel), 64'd1);

    // Bounce: 3 low, 1 high, then steady low.
    key_n[0] = 1'b0;
    repeat (3) tick();
    key_n[0] = 1'b1;
    tick();
    key_n[0] = 1'b0;
    push_pulse(cyc + 1 + DEB + 2, 1'b0, 1'b1);
    repeat (12) tick();
    key_n[0] = 1'b1;
    repeat (12) tick();

    // Channel wrap over three channels.
    ch_data = {32'h33333333, 32'h22222222, 32'h11111111};
    repeat (4) tick();
    press_ch(2'd0, 2'd1);
    press_ch(2'd1, 2'd2);
    press_ch(2'd2, 2'd0);
    press_ch(2'd0, 2'd1);

    // Display hold freezes the shown value; release shows new data two cycles later.
    display_hold = 1'b1;
    tick();
    ch_data = {NUM_CH{32'h44444444}};
    repeat (4) tick();
    chk("hold_freeze", 64'(hex_n), 64'({ND{chseg[1]}}));
    display_hold = 1'b0;
    push_hex(cyc + 1, {ND{chseg[1]}}, "hold_release_old");
    push_hex(cyc + 2, {ND{7'b0011001}}, "hold_release_new");
    repeat (4) tick();

    // Sticky LEDs.
    led_op(1'b1, 5'd5,  1'b0, 18'h00020, "led_set5");
    led_op(1'b1, 5'd17, 1'b0, 18'h20020, "led_set17");
    led_op(1'b1, 5'd20, 1'b0, 18'h20020, "led_ignore20");
    led_op(1'b1, 5'd3,  1'b1, 18'h00008, "led_clear_set3");
    led_op(1'b0, 5'd0,  1'b1, 18'h00000, "led_clear");
    led_op(1'b1, 5'd9,  1'b0, 18'h00200, "led_set9");

    // Reset mid-debounce: counter at 2 of 4 when reset is sampled.
    key_n[0] = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    chk("midrst_pulse", 64'(action_pulse), 64'd0);
    chk("midrst_ch_sel", 64'(ch_sel), 64'd0);
    chk("midrst_hex", 64'(hex_n), {8'h00, {56{1'b1}}});
    chk("midrst_ledr", 64'(ledr), 64'd0);
    reset = 1'b0;
    push_pulse(cyc + 1 + DEB + 2, 1'b0, 1'b1);
    repeat (12) tick();
    key_n[0] = 1'b1;
    repeat (12) tick();

    chk("pulse_queue_drained", 64'(pq.size()), 64'd0);
    chk("hex_queue_drained", 64'(hq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
